// File: rtl/mdio_receiver.sv
// Clause-22 MDIO slave: decodes master frames into register-file write/read strobes and returns read data serially.
// Latency: memory_rd 1 clk after the bit-14 mdc rise is seen, memory_wr 1 clk after bit 32; mdio_in updates 1 clk after mdc fall.
// Backpressure: none; the master paces everything through mdc, and the register file must answer one clk after memory_rd.
module mdio_receiver #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_oe,
    input  logic        mdio_out,
    output logic        mdio_in,
    output logic [4:0]  addr,
    output logic [15:0] wr_data,
    output logic        memory_wr,
    output logic        memory_rd,
    input  logic [15:0] rd_data,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WRITE_DATA,
        READ_TA,
        READ_DATA,
        SKIP
    } state_t;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [14:0] shreg;
    logic [15:0] shnext;
    logic [15:0] tx;
    logic        tx_load;
    logic        mdc_q;
    logic        mdc_rise;
    logic        mdc_fall;
    logic        phy_match;

    // mdc_q tracks mdc even in reset so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        mdc_q <= mdc;
    end

    assign mdc_rise  = mdc & ~mdc_q;
    assign mdc_fall  = ~mdc & mdc_q;
    assign shnext    = {shreg, mdio_out};
    // after 14 bits shnext[13:0] = ST, OP, PHYAD, REGAD
    assign phy_match = (shnext[9:5] == PHY_ADDR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 6'd0;
            shreg     <= 15'd0;
            tx        <= 16'd0;
            tx_load   <= 1'b0;
            mdio_in   <= 1'b0;
            addr      <= 5'd0;
            wr_data   <= 16'd0;
            memory_wr <= 1'b0;
            memory_rd <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            memory_wr <= 1'b0;
            memory_rd <= 1'b0;
            frame_err <= 1'b0;
            tx_load   <= 1'b0;
            if (tx_load) begin
                tx <= rd_data;
            end

            case (state)
                IDLE: begin
                    mdio_in <= 1'b0;
                    if (mdc_rise && mdio_oe && !mdio_out) begin
                        state   <= HEADER;
                        bit_cnt <= 6'd1;
                        shreg   <= shnext[14:0];
                    end
                end

                HEADER: begin
                    if (mdc_rise) begin
                        if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            bit_cnt   <= 6'd0;
                        end else begin
                            shreg   <= shnext[14:0];
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd1 && !mdio_out) begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                                bit_cnt   <= 6'd0;
                            end else if (bit_cnt == 6'd13) begin
                                addr <= shnext[4:0];
                                if (phy_match && shnext[11:10] == 2'b10) begin
                                    memory_rd <= 1'b1;
                                    tx_load   <= 1'b1;
                                    state     <= READ_TA;
                                end else if (phy_match && shnext[11:10] == 2'b01) begin
                                    state <= WRITE_DATA;
                                end else begin
                                    state <= SKIP;
                                end
                            end
                        end
                    end
                end

                WRITE_DATA: begin
                    if (mdc_rise) begin
                        if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            bit_cnt   <= 6'd0;
                        end else begin
                            shreg   <= shnext[14:0];
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                wr_data   <= shnext;
                                memory_wr <= 1'b1;
                                state     <= IDLE;
                                bit_cnt   <= 6'd0;
                            end
                        end
                    end
                end

                READ_TA: begin
                    mdio_in <= 1'b0;
                    if (mdc_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd15) begin
                            state <= READ_DATA;
                        end
                    end
                end

                READ_DATA: begin
                    if (mdc_fall) begin
                        mdio_in <= tx[15];
                        tx      <= {tx[14:0], 1'b0};
                    end
                    if (mdc_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) begin
                            mdio_in <= 1'b0;
                            state   <= IDLE;
                            bit_cnt <= 6'd0;
                        end
                    end
                end

                SKIP: begin
                    mdio_in <= 1'b0;
                    if (mdc_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) begin
                            state   <= IDLE;
                            bit_cnt <= 6'd0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= 6'd0;
                    mdio_in <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_receiver.sv
// Scoreboard bench for mdio_receiver: a master model shifts Clause-22 frames and queues the expected strobes and mdio_in bits.
// A separate monitor pops expectations whenever the DUT strobes or the master samples mdio_in.
module tb_mdio_receiver;

    localparam logic [4:0] PHY = 5'd0;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_oe = 1'b0;
    logic        mdio_out = 1'b1;
    logic        mdio_in;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        memory_wr;
    logic        memory_rd;
    logic [15:0] rd_data;
    logic        frame_err;

    logic [15:0] regs [32];
    assign rd_data = regs[addr];

    wr_t        exp_wr[$];
    logic [4:0] exp_rd[$];
    logic       exp_err[$];
    logic       exp_bit[$];

    int n_vec = 0;
    int n_bad = 0;
    int half  = 3;

    mdio_receiver #(.PHY_ADDR(PHY)) dut (
        .clk(clk),
        .reset(reset),
        .mdc(mdc),
        .mdio_oe(mdio_oe),
        .mdio_out(mdio_out),
        .mdio_in(mdio_in),
        .addr(addr),
        .wr_data(wr_data),
        .memory_wr(memory_wr),
        .memory_rd(memory_rd),
        .rd_data(rd_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: DUT strobed with nothing expected (t=%0t)", name, $time);
    endtask

    // strobe monitor
    always @(negedge clk) begin
        wr_t w;
        logic [4:0] ra;
        logic ev;
        if (memory_wr === 1'b1) begin
            if (exp_wr.size() == 0) unexpected("memory_wr");
            else begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(addr), 32'(w.a));
                check("wr_data", 32'(wr_data), 32'(w.d));
            end
        end
        if (memory_rd === 1'b1) begin
            if (exp_rd.size() == 0) unexpected("memory_rd");
            else begin
                ra = exp_rd.pop_front();
                check("rd_addr", 32'(addr), 32'(ra));
            end
        end
        if (frame_err === 1'b1) begin
            if (exp_err.size() == 0) unexpected("frame_err");
            else begin
                ev = exp_err.pop_front();
                check("frame_err", 32'(frame_err), 32'(ev));
            end
        end
    end

    // master samples mdio_in on every mdc rise
    always @(posedge mdc) begin
        logic eb;
        if (exp_bit.size() == 0) unexpected("mdio_in_sample");
        else begin
            eb = exp_bit.pop_front();
            check("mdio_in", 32'(mdio_in), 32'(eb));
        end
    end

    task automatic send_bit(input logic oe, input logic b, input logic e);
        @(negedge clk);
        mdio_oe  = oe;
        mdio_out = b;
        repeat (half - 1) @(negedge clk);
        exp_bit.push_back(e);
        mdc = 1'b1;
        repeat (half) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_mdio_in", 32'(mdio_in), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_memory_wr", 32'(memory_wr), 32'd0);
        check("rst_memory_rd", 32'(memory_rd), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    // abort_at: bit at which the master drops mdio_oe; rst_at: bit after which reset pulses
    task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] reg_a,
                              input logic [15:0] dat, input int abort_at, input int rst_at);
        logic [31:0] f;
        logic [15:0] rdv;
        logic        is_rd;
        logic        match;
        logic        oe;
        logic        b;
        logic        e;
        wr_t         w;
        f     = {2'b01, op, phy, reg_a, 2'b10, dat};
        is_rd = (op == 2'b10);
        match = (phy == PHY);
        rdv   = regs[reg_a];
        if (abort_at != 0) exp_err.push_back(1'b1);
        else if (rst_at == 0 && match && op == 2'b01) begin
            w.a = reg_a;
            w.d = dat;
            exp_wr.push_back(w);
        end else if (rst_at == 0 && match && is_rd) exp_rd.push_back(reg_a);
        half = $urandom_range(2, 4);
        for (int i = 1; i <= 32; i++) begin
            if (abort_at != 0 && i > abort_at) break;
            oe = !(is_rd && i > 14) && (i != abort_at) && !(rst_at != 0 && i > rst_at);
            b  = oe ? f[32-i] : 1'($urandom_range(0, 1));
            e  = 1'b0;
            if (match && is_rd && abort_at == 0 && rst_at == 0 && i >= 17) e = rdv[32-i];
            send_bit(oe, b, e);
            if (i == rst_at) begin
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check_reset_outputs();
            end
        end
    endtask

    task automatic bad_start();
        exp_err.push_back(1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        int          ab;
        logic [1:0]  op;
        logic [4:0]  phy;
        for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
        regs[3] = 16'hA5C3;

        repeat (4) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        preamble(32);
        send_frame(2'b01, PHY, 5'd5, 16'hBEEF, 0, 0);
        preamble(8);
        send_frame(2'b10, PHY, 5'd3, 16'h0000, 0, 0);
        preamble(4);
        send_frame(2'b01, 5'd7, 5'd9, 16'h7777, 0, 0);
        send_frame(2'b01, PHY, 5'd10, 16'h0F0F, 0, 0);
        preamble(4);
        bad_start();
        preamble(4);
        send_frame(2'b01, PHY, 5'd1, 16'h1234, 0, 0);
        preamble(4);
        send_frame(2'b01, PHY, 5'd6, 16'h5555, 0, 20);
        preamble(8);
        send_frame(2'b01, PHY, 5'd8, 16'hABCD, 0, 0);
        preamble(2);
        send_frame(2'b01, PHY, 5'd2, 16'h0001, 0, 0);
        send_frame(2'b01, PHY, 5'd31, 16'hFFFF, 0, 0);

        for (int n = 0; n < 40; n++) begin
            preamble($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) bad_start();
            else begin
                op  = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'($urandom_range(0, 3));
                phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : PHY;
                ab  = 0;
                if ($urandom_range(0, 7) == 0)
                    ab = $urandom_range(3, (phy == PHY && op == 2'b01) ? 32 : 14);
                send_frame(op, phy, 5'($urandom), 16'($urandom), ab, 0);
            end
        end
        preamble(2);
        repeat (10) @(negedge clk);

        check("wr_left", 32'(exp_wr.size()), 32'd0);
        check("rd_left", 32'(exp_rd.size()), 32'd0);
        check("err_left", 32'(exp_err.size()), 32'd0);
        check("final_mdio_in", 32'(mdio_in), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdio_receiver.md
# mdio_receiver

MDIO management-slave (PHY side) stage that sits directly downstream of the MDIO master controller. It decodes the serial 32-bit Clause-22 frames the master shifts out on `mdio_out`/`mdc`, performs register writes and reads against an external 16-bit register file, and returns read data serially on `mdio_in`. Everything runs in the single `clk` domain. `mdc` is treated as a data input and edge-detected.

## Interface
- `PHY_ADDR`, default 5'd0: PHY address this slave answers to.
- `clk`  in  1  system clock. All logic is clocked on its rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `mdc`  in  1  management clock from the master. Each high phase and each low phase is at least 2 `clk` cycles.
- `mdio_oe`  in  1  master output enable. When 1, `mdio_out` is valid.
- `mdio_out`  in  1  serial bit from the master, MSB first.
- `mdio_in`  out  1  serial bit returned to the master during the turnaround and data phases of a read.
- `addr`  out  5  register address, taken from the REGAD field.
- `wr_data`  out  16  write data for the register file.
- `memory_wr`  out  1  one-`clk` write strobe.
- `memory_rd`  out  1  one-`clk` read strobe.
- `rd_data`  in  16  register-file read data, valid on the `clk` edge after `memory_rd`.
- `frame_err`  out  1  one-`clk` pulse for a bad start code or an aborted frame.

## Operation
- Frame layout, MSB first, bits 31..0:
  - ST[31:30] = 01
  - OP[29:28]: 01 = write, 10 = read
  - PHYAD[27:23]
  - REGAD[22:18]
  - TA[17:16]
  - DATA[15:0]
- `mdc` rising edge (`mdc_rise`): `mdc` is 1 and the value registered on the previous `clk` cycle is 0. `mdc_fall` is defined the same way for the falling edge.
- A 6-bit `bit_cnt` counts the bits sampled on each `mdc_rise`. Sampling only happens while `mdio_oe` = 1; TA and DATA bits of a read are exempt.
- FSM states:
  - IDLE: on `mdc_rise` with `mdio_oe` = 1 and `mdio_out` = 0, go to HEADER with `bit_cnt` = 1. Preamble 1s are ignored.
  - HEADER: shift in bits. After bit 2, if ST ≠ 01: pulse `frame_err` and go to IDLE. After bit 14: latch OP, PHYAD and REGAD, and drive `addr` = REGAD.
    - OP = 10 and PHYAD = `PHY_ADDR`: pulse `memory_rd` on the next `clk`, capture `rd_data` into the TX shift register one `clk` later, go to READ_TA.
    - OP = 01 and PHYAD matches: go to WRITE_DATA.
    - Otherwise (PHY address mismatch or OP = 00/11): go to SKIP.
  - WRITE_DATA: sample TA and DATA on `mdc_rise`. After bit 32: `wr_data` = DATA, pulse `memory_wr` for one `clk`, go to IDLE.
  - READ_TA: on the first `mdc_fall` hold `mdio_in` = 0. At the second TA bit, `mdio_in` = 0 (slave drives zero). Go to READ_DATA.
  - READ_DATA: on each `mdc_fall`, update `mdio_in` with the next TX bit, MSB first, 16 bits. After the `mdc_rise` of bit 32: `mdio_in` = 0, go to IDLE.
  - SKIP: count `mdc_rise` edges up to 32, then go to IDLE. No strobes are issued and `mdio_in` stays 0.
- Abort: if `mdio_oe` = 0 at an `mdc_rise` during HEADER or WRITE_DATA, pulse `frame_err` and go to IDLE with no strobe.
- `mdio_in` is 0 whenever the FSM is not in READ_DATA.

## Timing
- Reset (synchronous, `reset` = 0): FSM = IDLE, `bit_cnt` = 0. All outputs are 0: `mdio_in`, `addr`, `wr_data`, `memory_wr`, `memory_rd`, `frame_err`.
- Reset mid-frame discards the frame entirely: no strobe is issued afterwards.
- `mdc_rise` and `mdc_fall` are detected 1 `clk` after the corresponding `mdc` transition.
- `memory_rd` asserts 1 `clk` after the detected `mdc_rise` of bit 14. The TX register is loaded 1 `clk` later, so it is ready well before the TA phase.
- `memory_wr` asserts 1 `clk` after the detected `mdc_rise` of bit 32. `addr` and `wr_data` are stable from that cycle until the next frame's bit 14.
- `mdio_in` changes exactly 1 `clk` after the detected `mdc_fall`. Each data bit is therefore stable at the master's `mdc` rising edge.
- Back-to-back frames: the first 0 of a new frame's ST may arrive on the `mdc_rise` immediately following bit 32 and must be accepted.

## Test plan
- Write frame 01_01_00000_00101_10_BEEF, `PHY_ADDR` = 0 → exactly one `memory_wr` pulse with `addr` = 5 and `wr_data` = 16'hBEEF. No `memory_rd`, no `frame_err`.
- Read frame 01_10_00000_00011, with the register file returning `rd_data` = 16'hA5C3 → one `memory_rd` pulse with `addr` = 3. `mdio_in` = 0 during TA, then the bits 1010_0101_1100_0011 in order, each sampled at a master `mdc` rise. `mdio_in` = 0 after the frame.
- Write frame with PHYAD = 5'd7 (mismatch) → no `memory_wr`/`memory_rd`, `mdio_in` stays 0, FSM back in IDLE after 32 bits.
- Frame starting 00 after preamble → `frame_err` pulse after bit 2, no strobes. A following valid write to REGAD 1 with data 16'h1234 succeeds.
- `reset` = 0 for 1 `clk` at bit 20 of a write → all outputs 0 and no `memory_wr`. A subsequent full write frame behaves normally.
- Two back-to-back writes, 16'h0001 to reg 2 then 16'hFFFF to reg 31, with no preamble between them → two `memory_wr` pulses with the matching `addr`/`wr_data` pairs.
